// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised multi-port register file.
// Imported by the interface, the read-port sub-module and the top.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

    // When both retire lanes target one register, this lane's data is kept.
    localparam lane_e PRIORITY_LANE = LANE_B;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Parameters must match the regfile_mp instance the bus is connected to.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);

    // No valid/ready: every strobe is sampled on each rising Clk; read data is
    // combinational (or one cycle later when the file registers its reads).
    logic [NREAD*AW-1:0]    ReadRegister;
    logic [NREAD*WIDTH-1:0] ReadData;
    logic [NREAD-1:0]       ReadBusy;
    logic                   WriteEnA;
    logic                   WriteEnB;
    logic [AW-1:0]          WriteRegA;
    logic [AW-1:0]          WriteRegB;
    logic [WIDTH-1:0]       WriteDataA;
    logic [WIDTH-1:0]       WriteDataB;
    logic                   Reserve;
    logic [AW-1:0]          ReserveReg;

    modport master (
        output ReadRegister, WriteEnA, WriteEnB, WriteRegA, WriteRegB,
               WriteDataA, WriteDataB, Reserve, ReserveReg,
        input  ReadData, ReadBusy
    );

    modport slave (
        input  ReadRegister, WriteEnA, WriteEnB, WriteRegA, WriteRegB,
               WriteDataA, WriteDataB, Reserve, ReserveReg,
        output ReadData, ReadBusy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One read port: address mux, write-lane bypass, zero-register masking and
// an optional output register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AW        = clog2(DEPTH),
    parameter int ZERO_REG  = 1,
    parameter int SYNC_READ = 0,
    parameter int BYPASS    = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] busyNext,
    input  logic             wrEnA,
    input  logic [AW-1:0]    wrRegA,
    input  logic [WIDTH-1:0] wrDataA,
    input  logic             wrEnB,
    input  logic [AW-1:0]    wrRegB,
    input  logic [WIDTH-1:0] wrDataB,
    output logic [WIDTH-1:0] data,
    output logic             busyOut
);

    logic             hitA;
    logic             hitB;
    logic [WIDTH-1:0] selData;
    logic             selBusy;
    logic [WIDTH-1:0] dataQ;
    logic             busyQ;

    assign hitA = (BYPASS != 0) && wrEnA && (wrRegA == addr);
    assign hitB = (BYPASS != 0) && wrEnB && (wrRegB == addr);

    always_comb begin
        selData = regs[addr];
        selBusy = busy[addr];
        // A bypassed read sees the register as it will be after this edge.
        if (hitA || hitB) begin
            selBusy = busyNext[addr];
            if (hitB && (PRIORITY_LANE == LANE_B || !hitA)) selData = wrDataB;
            else                                             selData = wrDataA;
        end
        if (ZERO_REG != 0 && addr == '0) begin
            selData = '0;
            selBusy = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dataQ <= '0;
            busyQ <= 1'b0;
        end else begin
            dataQ <= selData;
            busyQ <= selBusy;
        end
    end

    assign data    = (SYNC_READ != 0) ? dataQ : selData;
    assign busyOut = (SYNC_READ != 0) ? busyQ : selBusy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD read ports, two prioritised write lanes,
// bypass, optional registered reads and a per-register busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int NREAD     = 2,
    parameter int ZERO_REG  = 1,
    parameter int SYNC_READ = 0,
    parameter int BYPASS    = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    regfile_mp_if.slave  bus
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busyNext;
    logic                   wrEnA;
    logic                   wrEnB;
    logic                   resEn;
    logic                   firstEn;
    logic                   secondEn;
    logic [AW-1:0]          firstReg;
    logic [AW-1:0]          secondReg;
    logic [WIDTH-1:0]       firstData;
    logic [WIDTH-1:0]       secondData;
    logic [WIDTH-1:0]       portData [NREAD];
    logic [NREAD-1:0]       portBusy;
    logic [NREAD*WIDTH-1:0] readDataFlat;

    // A write during Reset is discarded, so it must not bypass either.
    assign wrEnA = bus.WriteEnA && !Reset && !(ZERO_REG != 0 && bus.WriteRegA == '0);
    assign wrEnB = bus.WriteEnB && !Reset && !(ZERO_REG != 0 && bus.WriteRegB == '0);
    assign resEn = bus.Reserve && !(ZERO_REG != 0 && bus.ReserveReg == '0);

    // The lane written second wins a same-address collision.
    assign firstEn    = (PRIORITY_LANE == LANE_B) ? wrEnA          : wrEnB;
    assign firstReg   = (PRIORITY_LANE == LANE_B) ? bus.WriteRegA  : bus.WriteRegB;
    assign firstData  = (PRIORITY_LANE == LANE_B) ? bus.WriteDataA : bus.WriteDataB;
    assign secondEn   = (PRIORITY_LANE == LANE_B) ? wrEnB          : wrEnA;
    assign secondReg  = (PRIORITY_LANE == LANE_B) ? bus.WriteRegB  : bus.WriteRegA;
    assign secondData = (PRIORITY_LANE == LANE_B) ? bus.WriteDataB : bus.WriteDataA;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (firstEn)  regs[firstReg]  <= firstData;
            if (secondEn) regs[secondReg] <= secondData;
        end
    end

    // Reserve is applied last: a newer producer keeps the register busy.
    always_comb begin
        busyNext = busy;
        if (wrEnA) busyNext[bus.WriteRegA] = 1'b0;
        if (wrEnB) busyNext[bus.WriteRegB] = 1'b0;
        if (resEn) busyNext[bus.ReserveReg] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) busy <= '0;
        else       busy <= busyNext;
    end

    for (genvar i = 0; i < NREAD; i++) begin : gRead
        regfile_read_port #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .AW        (AW),
            .ZERO_REG  (ZERO_REG),
            .SYNC_READ (SYNC_READ),
            .BYPASS    (BYPASS)
        ) uPort (
            .Clk      (Clk),
            .Reset    (Reset),
            .addr     (bus.ReadRegister[i*AW +: AW]),
            .regs     (regs),
            .busy     (busy),
            .busyNext (busyNext),
            .wrEnA    (wrEnA),
            .wrRegA   (bus.WriteRegA),
            .wrDataA  (bus.WriteDataA),
            .wrEnB    (wrEnB),
            .wrRegB   (bus.WriteRegB),
            .wrDataB  (bus.WriteDataB),
            .data     (portData[i]),
            .busyOut  (portBusy[i])
        );
    end

    always_comb begin
        readDataFlat = '0;
        for (int i = 0; i < NREAD; i++) readDataFlat[i*WIDTH +: WIDTH] = portData[i];
    end

    assign bus.ReadData = readDataFlat;
    assign bus.ReadBusy = portBusy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven in lockstep, checked
// against a behavioural model through expected-value queues.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W0 = 32, D0 = 32, A0 = 5, N0 = 2;
    localparam int W2 = 16, D2 = 8,  A2 = 3, N2 = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    // Config 0 stimulus (shared by the bypass and no-bypass instances)
    logic [N0*A0-1:0] rdReg0;
    logic             weA0, weB0, res0;
    logic [A0-1:0]    wrA0, wrB0, resReg0;
    logic [W0-1:0]    wdA0, wdB0;
    // Config 2 stimulus (registered reads, four ports)
    logic [N2*A2-1:0] rdReg2;
    logic             weA2, weB2, res2;
    logic [A2-1:0]    wrA2, wrB2, resReg2;
    logic [W2-1:0]    wdA2, wdB2;

    regfile_mp_if #(.WIDTH(W0), .AW(A0), .NREAD(N0)) bus0 ();
    regfile_mp_if #(.WIDTH(W0), .AW(A0), .NREAD(N0)) bus1 ();
    regfile_mp_if #(.WIDTH(W2), .AW(A2), .NREAD(N2)) bus2 ();

    assign bus0.ReadRegister = rdReg0;  assign bus1.ReadRegister = rdReg0;
    assign bus0.WriteEnA = weA0;        assign bus1.WriteEnA = weA0;
    assign bus0.WriteEnB = weB0;        assign bus1.WriteEnB = weB0;
    assign bus0.WriteRegA = wrA0;       assign bus1.WriteRegA = wrA0;
    assign bus0.WriteRegB = wrB0;       assign bus1.WriteRegB = wrB0;
    assign bus0.WriteDataA = wdA0;      assign bus1.WriteDataA = wdA0;
    assign bus0.WriteDataB = wdB0;      assign bus1.WriteDataB = wdB0;
    assign bus0.Reserve = res0;         assign bus1.Reserve = res0;
    assign bus0.ReserveReg = resReg0;   assign bus1.ReserveReg = resReg0;

    assign bus2.ReadRegister = rdReg2;
    assign bus2.WriteEnA = weA2;
    assign bus2.WriteEnB = weB2;
    assign bus2.WriteRegA = wrA2;
    assign bus2.WriteRegB = wrB2;
    assign bus2.WriteDataA = wdA2;
    assign bus2.WriteDataB = wdB2;
    assign bus2.Reserve = res2;
    assign bus2.ReserveReg = resReg2;

    regfile_mp #(.WIDTH(W0), .DEPTH(D0), .NREAD(N0), .ZERO_REG(1), .SYNC_READ(0), .BYPASS(1))
        dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    regfile_mp #(.WIDTH(W0), .DEPTH(D0), .NREAD(N0), .ZERO_REG(1), .SYNC_READ(0), .BYPASS(0))
        dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));
    regfile_mp #(.WIDTH(W2), .DEPTH(D2), .NREAD(N2), .ZERO_REG(1), .SYNC_READ(1), .BYPASS(1))
        dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

    // Reference model state and expected queues: {busy bits, data bits}
    logic [W0-1:0] mem0 [D0];
    bit            busy0 [D0];
    logic [W2-1:0] mem2 [D2];
    bit            busy2 [D2];
    logic [N0*W0+N0-1:0] exp0_q[$], exp1_q[$];
    logic [N2*W2+N2-1:0] exp2_q[$];
    logic [N2*W2+N2-1:0] pend2;
    logic [N0*W0+N0-1:0] e0, e1;
    logic [N2*W2+N2-1:0] e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- model, config 0 ----
    function automatic bit hit0(input int r);
        return r != 0 && ((weA0 && int'(wrA0) == r) || (weB0 && int'(wrB0) == r));
    endfunction
    function automatic logic [W0-1:0] nextData0(input int r);
        logic [W0-1:0] v;
        v = mem0[r];
        if (weA0 && int'(wrA0) == r) v = wdA0;
        if (weB0 && int'(wrB0) == r) v = wdB0;
        return (r == 0) ? '0 : v;
    endfunction
    function automatic bit nextBusy0(input int r);
        bit b;
        b = busy0[r];
        if (hit0(r)) b = 1'b0;
        if (res0 && int'(resReg0) == r) b = 1'b1;
        return (r == 0) ? 1'b0 : b;
    endfunction
    function automatic logic [N0*W0+N0-1:0] predict0(input bit bypass);
        logic [N0*W0-1:0] d;
        logic [N0-1:0]    b;
        int r;
        for (int i = 0; i < N0; i++) begin
            r = int'(rdReg0[i*A0 +: A0]);
            if (bypass && hit0(r)) begin d[i*W0 +: W0] = nextData0(r); b[i] = nextBusy0(r); end
            else                   begin d[i*W0 +: W0] = mem0[r];      b[i] = busy0[r];      end
        end
        return {b, d};
    endfunction

    // ---- model, config 2 ----
    function automatic bit hit2(input int r);
        return r != 0 && ((weA2 && int'(wrA2) == r) || (weB2 && int'(wrB2) == r));
    endfunction
    function automatic logic [W2-1:0] nextData2(input int r);
        logic [W2-1:0] v;
        v = mem2[r];
        if (weA2 && int'(wrA2) == r) v = wdA2;
        if (weB2 && int'(wrB2) == r) v = wdB2;
        return (r == 0) ? '0 : v;
    endfunction
    function automatic bit nextBusy2(input int r);
        bit b;
        b = busy2[r];
        if (hit2(r)) b = 1'b0;
        if (res2 && int'(resReg2) == r) b = 1'b1;
        return (r == 0) ? 1'b0 : b;
    endfunction
    function automatic logic [N2*W2+N2-1:0] predict2();
        logic [N2*W2-1:0] d;
        logic [N2-1:0]    b;
        int r;
        for (int i = 0; i < N2; i++) begin
            r = int'(rdReg2[i*A2 +: A2]);
            if (hit2(r)) begin d[i*W2 +: W2] = nextData2(r); b[i] = nextBusy2(r); end
            else         begin d[i*W2 +: W2] = mem2[r];      b[i] = busy2[r];      end
        end
        return {b, d};
    endfunction

    task automatic modelReset();
        for (int r = 0; r < D0; r++) begin mem0[r] = '0; busy0[r] = 1'b0; end
        for (int r = 0; r < D2; r++) begin mem2[r] = '0; busy2[r] = 1'b0; end
    endtask

    task automatic idle();
        rdReg0 = '0; weA0 = 0; weB0 = 0; wrA0 = '0; wrB0 = '0; wdA0 = '0; wdB0 = '0;
        res0 = 0; resReg0 = '0;
        rdReg2 = '0; weA2 = 0; weB2 = 0; wrA2 = '0; wrB2 = '0; wdA2 = '0; wdB2 = '0;
        res2 = 0; resReg2 = '0;
    endtask

    // Inputs are already applied; queue this cycle's expectations, clock, commit.
    task automatic step();
        exp0_q.push_back(predict0(1'b1));
        exp1_q.push_back(predict0(1'b0));
        pend2 = predict2();
        @(posedge Clk);
        #1;
        for (int r = 0; r < D0; r++) begin mem0[r] = nextData0(r); busy0[r] = nextBusy0(r); end
        for (int r = 0; r < D2; r++) begin mem2[r] = nextData2(r); busy2[r] = nextBusy2(r); end
        exp2_q.push_back(pend2);
    endtask

    // Monitor: pops one expectation per queue whenever one is due.
    always @(negedge Clk) begin
        if (exp0_q.size() > 0) begin
            e0 = exp0_q.pop_front();
            check("bypass data", 64'(bus0.ReadData), 64'(e0[N0*W0-1:0]));
            check("bypass busy", 64'(bus0.ReadBusy), 64'(e0[N0*W0 +: N0]));
        end
        if (exp1_q.size() > 0) begin
            e1 = exp1_q.pop_front();
            check("nobypass data", 64'(bus1.ReadData), 64'(e1[N0*W0-1:0]));
            check("nobypass busy", 64'(bus1.ReadBusy), 64'(e1[N0*W0 +: N0]));
        end
        if (exp2_q.size() > 0) begin
            e2 = exp2_q.pop_front();
            check("sync data", 64'(bus2.ReadData), 64'(e2[N2*W2-1:0]));
            check("sync busy", 64'(bus2.ReadBusy), 64'(e2[N2*W2 +: N2]));
        end
    end

    initial begin
        modelReset();
        idle();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset data0", 64'(bus0.ReadData), 64'(0));
        check("reset busy0", 64'(bus0.ReadBusy), 64'(0));
        check("reset data2", 64'(bus2.ReadData), 64'(0));
        check("reset busy2", 64'(bus2.ReadBusy), 64'(0));
        Reset = 1'b0;

        // Write reg5, then assert Reset before the edge: the write is lost.
        weA0 = 1; wrA0 = 5; wdA0 = 32'hDEADBEEF; rdReg0 = {5'd5, 5'd5};
        weA2 = 1; wrA2 = 5; wdA2 = 16'hBEEF;     rdReg2 = {3'd5, 3'd5, 3'd5, 3'd5};
        #1;
        check("prereset bypass", 64'(bus0.ReadData[W0-1:0]), 64'(32'hDEADBEEF));
        #1;
        Reset = 1'b1;
        #1;
        check("midreset data0", 64'(bus0.ReadData), 64'(0));
        check("midreset busy0", 64'(bus0.ReadBusy), 64'(0));
        check("midreset data2", 64'(bus2.ReadData), 64'(0));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle(); rdReg0 = {5'd5, 5'd5}; rdReg2 = {3'd5, 3'd5, 3'd5, 3'd5};
        step();

        // Dual write same address, then distinct addresses
        idle(); weA0 = 1; wrA0 = 7; wdA0 = 32'h11; weB0 = 1; wrB0 = 7; wdB0 = 32'h22;
        rdReg0 = {5'd7, 5'd7}; step();
        idle(); rdReg0 = {5'd7, 5'd7}; step();
        idle(); weA0 = 1; wrA0 = 3; wdA0 = 32'hA3; weB0 = 1; wrB0 = 4; wdB0 = 32'hB4;
        rdReg0 = {5'd4, 5'd3}; step();
        idle(); rdReg0 = {5'd4, 5'd3}; step();

        // Zero register ignores writes and reservations
        idle(); weA0 = 1; wrA0 = 0; wdA0 = 32'hFFFFFFFF; weB0 = 1; wrB0 = 0; wdB0 = 32'hFFFFFFFF;
        res0 = 1; resReg0 = 0; weA2 = 1; wrA2 = 0; wdA2 = 16'hFFFF; res2 = 1; resReg2 = 0;
        step();
        idle(); step();

        // Same-cycle bypass on port 1
        idle(); weA0 = 1; wrA0 = 9; wdA0 = 32'hCAFE; rdReg0 = {5'd9, 5'd0}; step();
        idle(); rdReg0 = {5'd9, 5'd9}; step();

        // Busy scoreboard on reg12
        idle(); res0 = 1; resReg0 = 12; rdReg0 = {5'd12, 5'd12}; step();
        idle(); rdReg0 = {5'd12, 5'd12}; step();
        idle(); weB0 = 1; wrB0 = 12; wdB0 = 32'h1234; rdReg0 = {5'd12, 5'd12}; step();
        idle(); rdReg0 = {5'd12, 5'd12}; step();
        idle(); res0 = 1; resReg0 = 12; weA0 = 1; wrA0 = 12; wdA0 = 32'h5678;
        rdReg0 = {5'd12, 5'd12}; step();
        idle(); rdReg0 = {5'd12, 5'd12}; step();

        // Registered reads: preload 1..4, read them, then move the addresses away
        idle(); weA2 = 1; wrA2 = 1; wdA2 = 16'h0001; weB2 = 1; wrB2 = 2; wdB2 = 16'h0002; step();
        idle(); weA2 = 1; wrA2 = 3; wdA2 = 16'h0003; weB2 = 1; wrB2 = 4; wdB2 = 16'h0004; step();
        idle(); rdReg2 = {3'd4, 3'd3, 3'd2, 3'd1}; step();
        idle(); rdReg2 = {3'd1, 3'd2, 3'd3, 3'd4}; step();
        idle(); step();

        // Randomised traffic with addresses folded to force collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N0; i++) rdReg0[i*A0 +: A0] = A0'($urandom_range(0, 15));
            weA0 = 1'($urandom); weB0 = 1'($urandom); res0 = 1'($urandom);
            wrA0 = A0'($urandom_range(0, 15)); wrB0 = A0'($urandom_range(0, 15));
            resReg0 = A0'($urandom_range(0, 15));
            wdA0 = $urandom; wdB0 = $urandom;
            for (int i = 0; i < N2; i++) rdReg2[i*A2 +: A2] = A2'($urandom_range(0, D2 - 1));
            weA2 = 1'($urandom); weB2 = 1'($urandom); res2 = 1'($urandom);
            wrA2 = A2'($urandom_range(0, D2 - 1)); wrB2 = A2'($urandom_range(0, D2 - 1));
            resReg2 = A2'($urandom_range(0, D2 - 1));
            wdA2 = W2'($urandom); wdB2 = W2'($urandom);
            step();
        end
        idle();

        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if (exp0_q.size() + exp1_q.size() + exp2_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     exp0_q.size() + exp1_q.size() + exp2_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
